multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the miniRV core. It walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It generates the per-step enables and the datapath select codes, including the 3-bit immediate-format select for the sign-extension unit, from a latched copy of the instruction word. It sits between the instruction/data memory handshakes and the shared datapath (PC, register file, SEXT, ALU), which the single-cycle core drives combinationally.

---
 rtl/multicycle_ctrl_pkg.sv | 114 +++++++++++
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl_decode.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 108 ++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Encodings for the miniRV multi-cycle sequencer:
// opcodes, datapath select codes, FSM states and decode bundles.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

   typedef enum logic [2:0] {
      IMM_I, IMM_SHIFT, IMM_S, IMM_U, IMM_B, IMM_J
   } imm_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
      ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE,
      ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
   } alu_e;

   typedef enum logic [1:0] {
      WB_ALU, WB_DMEM, WB_PC4, WB_IMM
   } wb_e;

   typedef enum logic [1:0] {
      NPC_PC4, NPC_PCIMM, NPC_ALU
   } npc_e;

   // Only the IR fields the control path looks at are kept.
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic       f7b5;
   } ir_t;

   typedef struct packed {
      imm_e sext;
      alu_e alu;
      wb_e  wb;
      npc_e npc;
      logic legal;
      logic mem;
      logic store;
      logic rf_wr;
   } dec_t;

   typedef struct packed {
      logic imem_req, dmem_req, dmem_we;
      logic ir_we, pc_we, rf_we, illegal;
      imm_e sext_op;
      alu_e alu_op;
      wb_e  wb_sel;
      npc_e npc_op;
   } out_t;

   localparam dec_t DEC_NOP = '{
      sext: IMM_I, alu: ALU_ADD, wb: WB_ALU,
      npc: NPC_PC4, legal: 1'b0, mem: 1'b0,
      store: 1'b0, rf_wr: 1'b1
   };

   localparam out_t OUT_RST = '{
      imem_req: 1'b0, dmem_req: 1'b0,
      dmem_we: 1'b0, ir_we: 1'b0,
      pc_we: 1'b0, rf_we: 1'b0,
      illegal: 1'b0, sext_op: IMM_I,
      alu_op: ALU_ADD, wb_sel: WB_ALU,
      npc_op: NPC_PC4
   };

   function automatic alu_e alu_arith(
      input logic [2:0] f3,
      input logic       alt
   );
      alu_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Reserved branch funct3 codes fall back to BEQ.
   function automatic alu_e alu_branch(
      input logic [2:0] f3
   );
      alu_e op;
      case (f3)
         3'b001:  op = ALU_BNE;
         3'b100:  op = ALU_BLT;
         3'b101:  op = ALU_BGE;
         3'b110:  op = ALU_BLTU;
         3'b111:  op = ALU_BGEU;
         default: op = ALU_BEQ;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshakes and datapath control bundle
// between the sequencer and the miniRV datapath.
interface multicycle_ctrl_if;
   import multicycle_ctrl_pkg::*;

   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        dmem_ack;
   logic        br_flag;
   logic        imem_req;
   logic        dmem_req;
   logic        dmem_we;
   logic        ir_we;
   logic        pc_we;
   logic        rf_we;
   logic        illegal;
   imm_e        sext_op;
   alu_e        alu_op;
   wb_e         wb_sel;
   npc_e        npc_op;

   modport master (
      input  imem_rdata, imem_ack,
      input  dmem_ack, br_flag,
      output imem_req, dmem_req, dmem_we,
      output ir_we, pc_we, rf_we, illegal,
      output sext_op, alu_op, wb_sel, npc_op
   );

   modport slave (
      output imem_rdata, imem_ack,
      output dmem_ack, br_flag,
      input  imem_req, dmem_req, dmem_we,
      input  ir_we, pc_we, rf_we, illegal,
      input  sext_op, alu_op, wb_sel, npc_op
   );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct map to datapath selects,
// memory/write-back class and a legal bit.
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  ir_t  ir_i,
   input  logic taken_i,
   output dec_t dec_o
);

   always_comb begin
      dec_o = DEC_NOP;
      unique case (1'b1)
         ir_i.opcode == OP_LUI: begin
            dec_o.legal = 1'b1;
            dec_o.sext  = IMM_U;
            dec_o.wb    = WB_IMM;
         end
         ir_i.opcode == OP_AUIPC: begin
            dec_o.legal = 1'b1;
            dec_o.sext  = IMM_U;
         end
         ir_i.opcode == OP_JAL: begin
            dec_o.legal = 1'b1;
            dec_o.sext  = IMM_J;
            dec_o.wb    = WB_PC4;
            dec_o.npc   = NPC_PCIMM;
         end
         ir_i.opcode == OP_JALR: begin
            dec_o.legal = 1'b1;
            dec_o.wb    = WB_PC4;
            dec_o.npc   = NPC_ALU;
         end
         ir_i.opcode == OP_BRANCH: begin
            dec_o.legal = 1'b1;
            dec_o.sext  = IMM_B;
            dec_o.alu   = alu_branch(ir_i.funct3);
            dec_o.npc   = taken_i ? NPC_PCIMM : NPC_PC4;
            dec_o.rf_wr = 1'b0;
         end
         ir_i.opcode == OP_LOAD: begin
            dec_o.legal = 1'b1;
            dec_o.wb    = WB_DMEM;
            dec_o.mem   = 1'b1;
         end
         ir_i.opcode == OP_STORE: begin
            dec_o.legal = 1'b1;
            dec_o.sext  = IMM_S;
            dec_o.mem   = 1'b1;
            dec_o.store = 1'b1;
            dec_o.rf_wr = 1'b0;
         end
         ir_i.opcode == OP_IMM: begin
            dec_o.legal = 1'b1;
            if (ir_i.funct3[1:0] == 2'b01)
               dec_o.sext = IMM_SHIFT;
            // funct7[5] only selects SRAI; ADDI has no SUB form
            dec_o.alu = alu_arith(ir_i.funct3,
               ir_i.funct3 == 3'b101 && ir_i.f7b5);
         end
         ir_i.opcode == OP_REG: begin
            dec_o.legal = 1'b1;
            dec_o.alu   = alu_arith(ir_i.funct3, ir_i.f7b5);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// miniRV multi-cycle sequencer: FETCH, DECODE, EXEC,
// optional MEM, WB, with a sticky TRAP for bad opcodes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   state_e state_q, state_d;
   ir_t    ir_q, ir_d;
   out_t   out_q, out_d;
   dec_t   dec;

   multicycle_ctrl_decode u_dec (
      .ir_i    (ir_q),
      .taken_i (bus.br_flag),
      .dec_o   (dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
         out_q   <= OUT_RST;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         out_q   <= out_d;
      end
   end

   // Outputs are registered: each step's pulses appear
   // the cycle after the state that decides them.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      out_d       = out_q;
      out_d.ir_we = 1'b0;
      out_d.pc_we = 1'b0;
      out_d.rf_we = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            out_d.imem_req = 1'b1;
            if (out_q.imem_req && bus.imem_ack) begin
               ir_d.opcode    = bus.imem_rdata[6:0];
               ir_d.funct3    = bus.imem_rdata[14:12];
               ir_d.f7b5      = bus.imem_rdata[30];
               out_d.imem_req = 1'b0;
               out_d.ir_we    = 1'b1;
               state_d        = S_DECODE;
            end
         end
         S_DECODE: begin
            if (dec.legal) begin
               out_d.sext_op = dec.sext;
               out_d.alu_op  = dec.alu;
               out_d.wb_sel  = dec.wb;
               state_d       = S_EXEC;
            end else begin
               out_d.illegal = 1'b1;
               state_d       = S_TRAP;
            end
         end
         S_EXEC: begin
            out_d.npc_op = dec.npc;
            if (dec.mem) begin
               out_d.dmem_req = 1'b1;
               out_d.dmem_we  = dec.store;
               state_d        = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               out_d.dmem_req = 1'b0;
               out_d.dmem_we  = 1'b0;
               state_d        = S_WB;
            end
         end
         S_WB: begin
            out_d.pc_we    = 1'b1;
            out_d.rf_we    = dec.rf_wr;
            out_d.imem_req = 1'b1;
            state_d        = S_FETCH;
         end
         S_TRAP: begin
            out_d.illegal = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.imem_req = out_q.imem_req;
   assign bus.dmem_req = out_q.dmem_req;
   assign bus.dmem_we  = out_q.dmem_we;
   assign bus.ir_we    = out_q.ir_we;
   assign bus.pc_we    = out_q.pc_we;
   assign bus.rf_we    = out_q.rf_we;
   assign bus.illegal  = out_q.illegal;
   assign bus.sext_op  = out_q.sext_op;
   assign bus.alu_op   = out_q.alu_op;
   assign bus.wb_sel   = out_q.wb_sel;
   assign bus.npc_op   = out_q.npc_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table, random and corner-case checks of multicycle_ctrl
// against a cycle-count model of the instruction timeline.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   exp_pc0 = 1'b0;
   bit   exp_rf0 = 1'b0;

   always #5 clk = ~clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   typedef struct {
      logic [31:0] instr;
      int          iw;
      int          dw;
      logic        br;
      imm_e        sext;
      alu_e        alu;
      wb_e         wb;
      npc_e        npc;
      bit          mem;
      bit          st;
      bit          rf;
   } vec_t;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic check_reset();
      chk("rst imem_req", bus.imem_req, 0);
      chk("rst dmem_req", bus.dmem_req, 0);
      chk("rst dmem_we", bus.dmem_we, 0);
      chk("rst ir_we", bus.ir_we, 0);
      chk("rst pc_we", bus.pc_we, 0);
      chk("rst rf_we", bus.rf_we, 0);
      chk("rst illegal", bus.illegal, 0);
      chk("rst sext_op", bus.sext_op, IMM_I);
      chk("rst alu_op", bus.alu_op, ALU_ADD);
      chk("rst wb_sel", bus.wb_sel, WB_ALU);
      chk("rst npc_op", bus.npc_op, NPC_PC4);
   endtask

   // Expected selects straight from the opcode rules.
   function automatic vec_t ref_model(input logic [31:0] w,
                                      input logic br);
      vec_t v;
      alu_e arith [8];
      logic [2:0] f3;
      int idx;
      arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      f3 = w[14:12];
      v = '{instr: w, iw: 0, dw: 0, br: br, sext: IMM_I,
            alu: ALU_ADD, wb: WB_ALU, npc: NPC_PC4,
            mem: 1'b0, st: 1'b0, rf: 1'b1};
      case (w[6:0])
         7'h37: begin v.sext = IMM_U; v.wb = WB_IMM; end
         7'h17: v.sext = IMM_U;
         7'h6F: begin
            v.sext = IMM_J; v.wb = WB_PC4; v.npc = NPC_PCIMM;
         end
         7'h67: begin v.wb = WB_PC4; v.npc = NPC_ALU; end
         7'h63: begin
            v.sext = IMM_B;
            v.rf   = 1'b0;
            v.npc  = br ? NPC_PCIMM : NPC_PC4;
            idx = f3[2] ? int'(f3) - 2 : (f3[1] ? 0 : int'(f3));
            v.alu = alu_e'(4'(10 + idx));
         end
         7'h03: begin v.wb = WB_DMEM; v.mem = 1'b1; end
         7'h23: begin
            v.sext = IMM_S; v.mem = 1'b1; v.st = 1'b1; v.rf = 1'b0;
         end
         7'h13: begin
            v.sext = (f3 == 1 || f3 == 5) ? IMM_SHIFT : IMM_I;
            v.alu  = (f3 == 5 && w[30]) ? ALU_SRA : arith[f3];
         end
         7'h33: begin
            if (w[30] && f3 == 0)      v.alu = ALU_SUB;
            else if (w[30] && f3 == 5) v.alu = ALU_SRA;
            else                       v.alu = arith[f3];
         end
         default: ;
      endcase
      return v;
   endfunction

   // Fetch ends at cycle iw, EXEC is iw+2, MEM (if any)
   // spans iw+3..iw+3+dw; pc_we lands on the next cycle 0.
   task automatic run_instr(input vec_t v, input bit rnd_br);
      int len;
      int ms;
      bit in_mem;
      len = v.iw + 4 + (v.mem ? v.dw + 1 : 0);
      ms  = v.iw + 3;
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         in_mem = v.mem && c >= ms && c <= ms + v.dw;
         chk("imem_req", bus.imem_req, c <= v.iw);
         chk("ir_we", bus.ir_we, c == v.iw + 1);
         chk("dmem_req", bus.dmem_req, in_mem);
         chk("dmem_we", bus.dmem_we, in_mem && v.st);
         chk("pc_we", bus.pc_we, c == 0 ? exp_pc0 : 1'b0);
         chk("rf_we", bus.rf_we, c == 0 ? exp_rf0 : 1'b0);
         chk("illegal", bus.illegal, 0);
         if (c >= v.iw + 2) begin
            chk("sext_op", bus.sext_op, v.sext);
            chk("alu_op", bus.alu_op, v.alu);
            chk("wb_sel", bus.wb_sel, v.wb);
         end
         if (c >= v.iw + 3)
            chk("npc_op", bus.npc_op, v.npc);
         bus.imem_rdata = (c == v.iw) ? v.instr : $urandom();
         if (c == v.iw)     bus.imem_ack = 1'b1;
         else if (c > v.iw) bus.imem_ack = 1'($urandom_range(0, 1));
         else               bus.imem_ack = 1'b0;
         if (in_mem) bus.dmem_ack = (c == ms + v.dw);
         else        bus.dmem_ack = 1'($urandom_range(0, 1));
         if (c == v.iw + 2 || !rnd_br) bus.br_flag = v.br;
         else bus.br_flag = 1'($urandom_range(0, 1));
      end
      exp_pc0 = 1'b1;
      exp_rf0 = v.rf;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (cycles) @(negedge clk);
      check_reset();
      rst_n = 1'b1;
      exp_pc0 = 1'b0;
      exp_rf0 = 1'b0;
   endtask

   vec_t        tab [11];
   vec_t        v;
   logic [6:0]  ops [9];
   logic [31:0] w;

   initial begin
      rst_n          = 1'b0;
      bus.imem_rdata = '0;
      bus.imem_ack   = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.br_flag    = 1'b0;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
              7'h03, 7'h23, 7'h13, 7'h33};

      tab[0]  = '{32'h00500093, 0, 0, 1'b0, IMM_I, ALU_ADD,
                  WB_ALU, NPC_PC4, 0, 0, 1};
      tab[1]  = '{32'h00112423, 1, 3, 1'b0, IMM_S, ALU_ADD,
                  WB_ALU, NPC_PC4, 1, 1, 0};
      tab[2]  = '{32'h00000863, 0, 0, 1'b1, IMM_B, ALU_BEQ,
                  WB_ALU, NPC_PCIMM, 0, 0, 0};
      tab[3]  = '{32'h00000863, 2, 0, 1'b0, IMM_B, ALU_BEQ,
                  WB_ALU, NPC_PC4, 0, 0, 0};
      tab[4]  = '{32'h00219193, 0, 0, 1'b0, IMM_SHIFT, ALU_SLL,
                  WB_ALU, NPC_PC4, 0, 0, 1};
      tab[5]  = '{32'h008000EF, 0, 0, 1'b0, IMM_J, ALU_ADD,
                  WB_PC4, NPC_PCIMM, 0, 0, 1};
      tab[6]  = '{32'h12345037, 1, 0, 1'b0, IMM_U, ALU_ADD,
                  WB_IMM, NPC_PC4, 0, 0, 1};
      tab[7]  = '{32'h00812083, 0, 0, 1'b0, IMM_I, ALU_ADD,
                  WB_DMEM, NPC_PC4, 1, 0, 1};
      tab[8]  = '{32'h000080E7, 0, 0, 1'b1, IMM_I, ALU_ADD,
                  WB_PC4, NPC_ALU, 0, 0, 1};
      tab[9]  = '{32'h402081B3, 0, 0, 1'b0, IMM_I, ALU_SUB,
                  WB_ALU, NPC_PC4, 0, 0, 1};
      tab[10] = '{32'h4032D293, 3, 0, 1'b0, IMM_SHIFT, ALU_SRA,
                  WB_ALU, NPC_PC4, 0, 0, 1};

      do_reset(3);
      for (int i = 0; i < 11; i++)
         run_instr(tab[i], 1'b0);

      // Reset while a load waits in MEM, then a stray dmem_ack.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("pre-mem pc_we", bus.pc_we, exp_pc0);
            chk("pre-mem rf_we", bus.rf_we, exp_rf0);
         end
         if (c == 3) chk("mem dmem_req", bus.dmem_req, 1);
         bus.imem_rdata = 32'h00812083;
         bus.imem_ack   = (c == 0);
         bus.dmem_ack   = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset();
      rst_n        = 1'b1;
      bus.dmem_ack = 1'b1;
      exp_pc0      = 1'b0;
      exp_rf0      = 1'b0;
      run_instr(tab[0], 1'b0);

      for (int i = 0; i < 150; i++) begin
         w      = $urandom();
         w[6:0] = ops[$urandom_range(0, 8)];
         v      = ref_model(w, 1'($urandom_range(0, 1)));
         v.iw   = $urandom_range(0, 3);
         v.dw   = $urandom_range(0, 3);
         run_instr(v, 1'b1);
      end

      // Unsupported opcode: sticky TRAP with acks ignored.
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("pre-trap pc_we", bus.pc_we, exp_pc0);
            chk("pre-trap rf_we", bus.rf_we, exp_rf0);
         end
         if (c == 1) chk("trap ir_we", bus.ir_we, 1);
         if (c >= 2) begin
            chk("trap illegal", bus.illegal, 1);
            chk("trap imem_req", bus.imem_req, 0);
            chk("trap dmem_req", bus.dmem_req, 0);
            chk("trap pc_we", bus.pc_we, 0);
            chk("trap rf_we", bus.rf_we, 0);
            chk("trap ir_we", bus.ir_we, 0);
         end
         bus.imem_rdata = (c == 0) ? 32'h0000007F : $urandom();
         bus.imem_ack   = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         bus.dmem_ack   = 1'($urandom_range(0, 1));
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset();
      rst_n   = 1'b1;
      exp_pc0 = 1'b0;
      exp_rf0 = 1'b0;
      run_instr(tab[4], 1'b0);

      @(negedge clk);
      chk("final pc_we", bus.pc_we, exp_pc0);
      chk("final rf_we", bus.rf_we, exp_rf0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
